// File: rtl/result_readout_buffer.sv
// Circular result store between the search core and host registers; one word per host level edge.
// Enqueue/dequeue visible one cycle later; no backpressure to the core; words are dropped and counted when full.
module result_readout_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  input  logic                         last_in,
  input  logic                         batch_mode_in,
  input  logic                         host_deq_in,
  input  logic                         flush_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic [$clog2(DEPTH+1)-1:0]   committed_out,
  output logic                         full_out,
  output logic                         overflow_out,
  output logic [CNT_W-1:0]             drop_count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_committed;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_drop_count;
  logic                  r_deq_prev;

  logic                  w_full;
  logic                  w_deq_req;
  logic                  w_deq;
  logic                  w_enq;
  logic                  w_drop;
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         w_committed_next;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_deq_req = host_deq_in & ~r_deq_prev;

  // Flush wins over any same-cycle traffic, so it gates every state-changing strobe.
  assign w_deq  = w_deq_req && (r_committed != '0) && !flush_in;
  assign w_enq  = valid_in && (!w_full || w_deq) && !flush_in;
  assign w_drop = valid_in && w_full && !w_deq && !flush_in;

  assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

  // A frame's last word releases everything stored, even if that word itself was dropped.
  always_comb begin
    w_committed_next = r_committed - CW'(w_deq);
    if (!batch_mode_in || (valid_in && last_in)) begin
      w_committed_next = w_count_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    r_deq_prev <= host_deq_in;
    if (rst_in || flush_in) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_committed  <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count     <= w_count_next;
      r_committed <= w_committed_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + CNT_W'(1);
        end
      end
    end
  end

  assign data_out       = r_mem[r_rd_ptr];
  assign data_valid_out = (r_committed != '0);
  assign count_out      = r_count;
  assign committed_out  = r_committed;
  assign full_out       = w_full;
  assign overflow_out   = r_overflow;
  assign drop_count_out = r_drop_count;

endmodule
